// File: rtl/riscv_muldiv_pkg.sv
// Shared op/state encodings and operand-signedness helpers for the M-extension unit.
// Combinational helpers only; no latency or flow control lives here.
package riscv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_mul_op(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_rem_op(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Radix-2 RV32M/RV64M mul/div; done DATA_W+1 cycles after accept (1 for div-by-zero/overflow).
// One op at a time: start is taken only while ready, busy stalls the pipe; flush/reset abort.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              flush,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    muldiv_op_e          op_in;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [DATA_W-1:0]   it_acc, it_lo;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fin;

    assign op_in  = muldiv_op_e'(funct3);
    assign sign_a = is_signed_a(op_in) & src_a[DATA_W-1];
    assign sign_b = is_signed_b(op_in) & src_b[DATA_W-1];
    assign abs_a  = sign_a ? -src_a : src_a;
    assign abs_b  = sign_b ? -src_b : src_b;

    // acc/lo hold {product hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : {(DATA_W+1){1'b0}});
        div_shift = {acc_q, lo_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (is_mul_op(op_q)) begin
            it_acc = mul_sum[DATA_W:1];
            it_lo  = {mul_sum[0], lo_q[DATA_W-1:1]};
        end else if (!div_diff[DATA_W]) begin
            it_acc = div_diff[DATA_W-1:0];
            it_lo  = {lo_q[DATA_W-2:0], 1'b1};
        end else begin
            it_acc = div_shift[DATA_W-1:0];
            it_lo  = {lo_q[DATA_W-2:0], 1'b0};
        end
        prod = neg_q ? -{it_acc, it_lo} : {it_acc, it_lo};
        case (op_q)
            OP_MUL:                       fin = prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:              fin = neg_q ? -it_lo : it_lo;
            default:                      fin = neg_q ? -it_acc : it_acc;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        tag_out_d = tag_out_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        m_d       = m_q;
        res_d     = res_q;
        result_d  = result_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = op_in;
                    tag_d = tag_in;
                    cnt_d = CNT_W'(DATA_W-1);
                    m_d   = is_mul_op(op_in) ? abs_a : abs_b;
                    lo_d  = is_mul_op(op_in) ? abs_b : abs_a;
                    acc_d = '0;
                    neg_d = (is_rem_op(op_in) && !is_mul_op(op_in)) ? sign_a : (sign_a ^ sign_b);
                    if (!is_mul_op(op_in) && src_b == '0) begin
                        res_d   = is_rem_op(op_in) ? src_a : '1;
                        state_d = DONE;
                    end else if (op_in inside {OP_DIV, OP_REM} && src_a == MOST_NEG && src_b == '1) begin
                        res_d   = is_rem_op(op_in) ? '0 : src_a;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = it_acc;
                    lo_d  = it_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        res_d   = fin;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d  = res_q;
                    tag_out_d = tag_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            tag_q     <= '0;
            tag_out_q <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            res_q     <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            tag_out_q <= tag_out_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            m_q       <= m_d;
            res_q     <= res_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
        end
    end

    // A flush or reset landing in the DONE cycle hides that op entirely
    logic show_done;
    assign show_done = (state_q == DONE) && !flush && !reset;

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign done    = show_done;
    assign result  = show_done ? res_q : result_q;
    assign tag_out = show_done ? tag_q : tag_out_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed checks of the mul/div unit at DATA_W=32 and DATA_W=8.
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;

    logic        start32, ready32, busy32, done32;
    logic [2:0]  f32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  tin32, tout32;

    logic        start8, ready8, busy8, done8;
    logic [2:0]  f8;
    logic [7:0]  a8, b8, res8;
    logic [4:0]  tin8, tout8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_muldiv #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .funct3(f32),
        .src_a(a32), .src_b(b32), .tag_in(tin32), .flush(flush),
        .ready(ready32), .busy(busy32), .done(done32),
        .result(res32), .tag_out(tout32)
    );

    riscv_muldiv #(.DATA_W(8), .TAG_W(5)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .funct3(f8),
        .src_a(a8), .src_b(b8), .tag_in(tin8), .flush(flush),
        .ready(ready8), .busy(busy8), .done(done8),
        .result(res8), .tag_out(tout8)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic do_op(input bit w8, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int exp_cyc, input string name);
        int cyc;
        cyc = 0;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; f8 = f; a8 = a[7:0]; b8 = b[7:0]; tin8 = tag;
        end else begin
            start32 = 1'b1; f32 = f; a32 = a; b32 = b; tin32 = tag;
        end
        for (int k = 1; k <= 60 && cyc == 0; k++) begin
            @(negedge clk);
            start8  = 1'b0;
            start32 = 1'b0;
            if (k == 1) chk({name, " busy"}, w8 ? busy8 : busy32, 1);
            if ((w8 ? done8 : done32) === 1'b1) cyc = k;
        end
        chk({name, " done cycle"}, cyc, exp_cyc);
        chk({name, " result"}, w8 ? {24'h0, res8} : res32, exp);
        chk({name, " tag"}, w8 ? tout8 : tout32, tag);
        @(negedge clk);
        chk({name, " ready after"}, w8 ? ready8 : ready32, 1);
        chk({name, " done pulse"}, w8 ? done8 : done32, 0);
    endtask

    initial begin
        bit saw;
        reset = 1'b1; flush = 1'b0;
        start32 = 1'b0; f32 = 3'b0; a32 = '0; b32 = '0; tin32 = '0;
        start8 = 1'b0; f8 = 3'b0; a8 = '0; b8 = '0; tin8 = '0;
        repeat (2) @(negedge clk);
        chk("rst ready", ready32, 1);
        chk("rst busy", busy32, 0);
        chk("rst done", done32, 0);
        chk("rst result", res32, 0);
        chk("rst tag", tout32, 0);
        chk("rst8 ready", ready8, 1);
        chk("rst8 result", res8, 0);
        reset = 1'b0;

        do_op(0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, "mul");
        do_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33, "mulh");
        do_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33, "mulhu");
        do_op(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33, "mulhsu");
        do_op(0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33, "div");
        do_op(0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33, "rem");
        do_op(0, 3'b101, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'hFFFF_FFFF, 1,  "divu0");
        do_op(0, 3'b111, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'h0000_0005, 1,  "remu0");
        do_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  "div ovf");
        do_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1,  "rem ovf");
        do_op(0, 3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        33, "divu");
        do_op(0, 3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         33, "remu");

        // Flush mid-divide, with an ignored start while busy
        @(negedge clk);
        start32 = 1'b1; f32 = 3'b100; a32 = 32'd1000; b32 = 32'd3; tin32 = 5'd20;
        saw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done32) saw = 1'b1;
            if (k == 1) start32 = 1'b0;
            if (k == 5) begin
                chk("flush ready in calc", ready32, 0);
                start32 = 1'b1; a32 = 32'd9; b32 = 32'd9; tin32 = 5'd21;
            end
            if (k == 6) start32 = 1'b0;
            if (k == 10) flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                chk("flush ready", ready32, 1);
                chk("flush busy", busy32, 0);
            end
        end
        chk("flush no done", saw, 0);
        chk("flush result kept", res32, 32'd2);
        chk("flush tag kept", tout32, 5'd14);
        do_op(0, 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 33, "mul after flush");

        // Reset in the middle of a MULH
        @(negedge clk);
        start32 = 1'b1; f32 = 3'b001; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; tin32 = 5'd22;
        saw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start32 = 1'b0;
            if (done32) saw = 1'b1;
            if (k == 20) reset = 1'b1;
        end
        @(negedge clk);
        chk("mreset ready", ready32, 1);
        chk("mreset busy", busy32, 0);
        chk("mreset done", done32, 0);
        chk("mreset result", res32, 0);
        chk("mreset tag", tout32, 0);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done32) saw = 1'b1;
        end
        chk("mreset no done", saw, 0);

        do_op(1, 3'b100, 32'h80, 32'hFF, 5'd1, 32'h80, 1, "w8 div ovf");
        do_op(1, 3'b000, 32'h10, 32'h10, 5'd2, 32'h00, 9, "w8 mul");
        do_op(1, 3'b101, 32'd200, 32'd7, 5'd3, 32'd28, 9, "w8 divu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative, parametrised RV32M/RV64M multiply/divide unit for the pipelined RISC-V core. It sits beside the EX-stage ALU and accepts one M-extension operation at a time. It computes in radix-2 (one bit per cycle), asserts `busy` so the hazard logic can stall earlier stages, and returns the result with its destination-register tag for writeback. Divide-by-zero and signed overflow follow the RISC-V M spec and complete early.

## Interface
- `DATA_W`, 32: operand/result width; must be even and ≥ 8.
- `TAG_W`, 5: destination-register tag width.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `funct3`  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a`  in  DATA_W  rs1 operand.
- `src_b`  in  DATA_W  rs2 operand.
- `tag_in`  in  TAG_W  destination register.
- `flush`  in  1  abort any in-flight op (branch/jump redirect).
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in CALC and DONE; drives pipeline stall.
- `done`  out  1  one-cycle pulse, result valid.
- `result`  out  DATA_W  final value, held from `done` until next accept.
- `tag_out`  out  TAG_W  tag of the completed op, held with `result`.

## Operation
- States: IDLE → CALC → DONE → IDLE. IDLE → DONE is taken directly for special cases.
- Accept = `start` & `ready` & !`flush`. On accept:
  - latch `funct3` and `tag_in`;
  - latch |a| and |b| for signed operands, per op: MUL/MULH both signed, MULHSU a signed only, DIV/REM both signed;
  - record result-negate flag; load counter with DATA_W-1.
- Multiply:
  - shift-add over a 2·DATA_W product register.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word after sign fix, where sign fix is the two's-complement negate of the full 2·DATA_W product.
- Divide: restoring shift-subtract.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases, result in DONE with no CALC:
  - b=0: DIV/DIVU → all-ones; REM/REMU → a.
  - a=most-negative and b=-1, signed only: DIV → a; REM → 0.
- CALC: one iteration per edge; counter decrements; at counter=0 the iteration completes and the state moves to DONE with `result` registered.
- DONE: `done`=1 for exactly one cycle; next edge → IDLE.
- `start` while not ready: ignored; no queueing.
- `flush` in CALC or DONE: next edge → IDLE, `done` suppressed, `result`/`tag_out` retain prior values.
- `flush` with `start` in IDLE: start ignored.
- All arithmetic modulo 2^DATA_W; most-negative × most-negative handled exactly via the 2·DATA_W register.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0, `tag_out`=0, counter=0.
- Reset in any state: IDLE next edge; `done` never asserted for the aborted op.
- Normal latency: accept at edge E0. `done` is high in the cycle after edge E_DATA_W, which is cycle DATA_W+1 counting the start cycle as 0. `ready` returns one cycle later.
- Special-case latency: `done` in cycle 1.
- Back-to-back throughput: one op per DATA_W+2 cycles. `start` may be held high; it is re-accepted in the first IDLE cycle.
- `busy` rises combinationally from state, i.e. in cycle 1, not in the accept cycle. The hazard unit must OR `start`&`ready` into its stall.

## Structure
- Package `riscv_muldiv_pkg`:
  - `muldiv_op_e` enum on funct3 codes;
  - `muldiv_state_e` {IDLE, CALC, DONE};
  - helper function `is_signed_a/b(op)`.
- Single module, no sub-module required. Sign-fix negation stays inline.
- Counter width `$clog2(DATA_W)`.

## Test plan
- DATA_W=32, MUL 7 × 0xFFFFFFFD (-3) → `result`=0xFFFFFFEB, `done` exactly in cycle 33, `tag_out`=tag_in.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Each with `done` in cycle 1.
- Start DIV, pulse `start` with new operands at cycle 5 (ignored), `flush` at cycle 10 → no `done`, `ready`=1 at cycle 11; next MUL 3×4 → 12.
- Assert `reset` at cycle 20 of a MULH → all outputs at reset values next cycle, no `done`. Repeat with DATA_W=8: DIV 0x80/0xFF → 0x80 in cycle 1, MUL 0x10×0x10 → 0x00 in cycle 9.
